// File: rtl/scytale_encryption.sv
`default_nettype none
// ============================================================================
// Module      : scytale_encryption
// Description : Scytale (columnar transposition) encryptor. Characters arrive
//               on data_i/valid_i and are buffered in IDLE. A
//               START_ENCRYPTION_TOKEN latches the grid size (key_N rows x
//               key_M columns). The stored text is then read out one cell
//               per cycle, column by column, from plaintext cell p = M*i + j.
//               Optional feature macro: SCYTALE_ENC_PAD_EN. When it is defined,
//               empty cells are sent as PAD_CHAR with valid_o high. When it is
//               not defined, empty cells produce a valid_o gap.
// Ports       : clk     - clock, all state updates on the rising edge
//               rst_n   - asynchronous active-low reset
//               data_i  - plaintext character or start token
//               valid_i - data_i qualifier
//               key_N   - grid rows, latched when the token is accepted
//               key_M   - grid columns, latched when the token is accepted
//               data_o  - ciphertext character (registered)
//               valid_o - data_o qualifier (registered)
//               busy    - high while encrypting; all input is ignored then
// Revision    : 1.0 - initial release
// ============================================================================
module scytale_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR               = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int c_IDX_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    // The cell index must hold M*i + j without wrapping.
    localparam int c_P_W   = 2 * KEY_WIDTH;

    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_NOF_CHARS);
    localparam logic [c_P_W-1:0]   c_MAX_CELL = c_P_W'(MAX_NOF_CHARS);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_ENCRYPT = 1'b1;

    logic [0:0]           r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [KEY_WIDTH-1:0] r_key_n;
    logic [KEY_WIDTH-1:0] r_key_m;
    logic [KEY_WIDTH-1:0] r_row;
    logic [KEY_WIDTH-1:0] r_col;
    logic                 r_fin;
    logic [D_WIDTH-1:0]   r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];

    logic [0:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [KEY_WIDTH-1:0] w_key_n_nxt;
    logic [KEY_WIDTH-1:0] w_key_m_nxt;
    logic [KEY_WIDTH-1:0] w_row_nxt;
    logic [KEY_WIDTH-1:0] w_col_nxt;
    logic                 w_fin_nxt;
    logic [D_WIDTH-1:0]   w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic                 w_wr_en;

    logic [c_P_W-1:0]     w_cell;
    logic                 w_empty;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [D_WIDTH-1:0]   w_rd_data;
    logic                 w_zero_grid;
    logic                 w_row_end;
    logic                 w_col_end;

    // Plaintext cell addressed by the current (row, column) walk position.
    assign w_cell = ({{KEY_WIDTH{1'b0}}, r_key_m} * {{KEY_WIDTH{1'b0}}, r_row})
                  + {{KEY_WIDTH{1'b0}}, r_col};

    assign w_empty     = (w_cell >= c_P_W'(r_count)) || (w_cell >= c_MAX_CELL);
    assign w_rd_idx    = w_cell[c_IDX_W-1:0];
    assign w_rd_data   = r_buf[w_rd_idx];
    assign w_zero_grid = (r_key_n == '0) || (r_key_m == '0);
    assign w_row_end   = (r_row == r_key_n - KEY_WIDTH'(1));
    assign w_col_end   = (r_col == r_key_m - KEY_WIDTH'(1));

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign busy    = r_busy;

    // Character buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_count[c_IDX_W-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_key_n <= '0;
            r_key_m <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_fin   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_key_n <= w_key_n_nxt;
            r_key_m <= w_key_m_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_fin   <= w_fin_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_key_n_nxt = r_key_n;
        w_key_m_nxt = r_key_m;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_fin_nxt   = r_fin;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_wr_en     = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (valid_i) begin
                    if (data_i != START_ENCRYPTION_TOKEN) begin
                        // Characters past the buffer depth are dropped.
                        if (r_count < c_MAX_CNT) begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = r_count + c_CNT_W'(1);
                        end
                    end else if (r_count != '0) begin
                        w_key_n_nxt = key_N;
                        w_key_m_nxt = key_M;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_fin_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = c_ENCRYPT;
                    end
                end
            end

            c_ENCRYPT: begin
                // r_fin marks that the final cell went out on the previous edge;
                // an empty grid finishes right away.
                if (r_fin || w_zero_grid) begin
                    w_state_nxt = c_IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_count_nxt = '0;
                end else begin
                    if (w_empty) begin
`ifdef SCYTALE_ENC_PAD_EN
                        w_data_nxt  = PAD_CHAR;
                        w_valid_nxt = 1'b1;
`else
                        // The gap cycle keeps the last character on data_o.
                        w_valid_nxt = 1'b0;
`endif
                    end else begin
                        w_data_nxt  = w_rd_data;
                        w_valid_nxt = 1'b1;
                    end

                    // Row index runs fastest, so output is column-major.
                    if (w_row_end) begin
                        w_row_nxt = '0;
                        w_col_nxt = r_col + KEY_WIDTH'(1);
                    end else begin
                        w_row_nxt = r_row + KEY_WIDTH'(1);
                    end
                    w_fin_nxt = w_row_end && w_col_end;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/scytale_encryption.md
SCYTALE_ENCRYPTION -- requirements
Module: scytale_encryption

Interface
REQ-001 SHALL have parameter D_WIDTH, 8, character width in bits.
REQ-002 SHALL have parameter KEY_WIDTH, 8, key field width.
REQ-003 SHALL have parameter MAX_NOF_CHARS, 50, character buffer depth.
REQ-004 SHALL have parameter START_ENCRYPTION_TOKEN, 8'hFA, end-of-plaintext marker.
REQ-005 SHALL have parameter PAD_CHAR, 8'h20, filler for empty grid cells.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 data_i  input  D_WIDTH  plaintext character or token.
REQ-009 valid_i  input  1  data_i qualifier.
REQ-010 key_N  input  KEY_WIDTH  grid rows.
REQ-011 key_M  input  KEY_WIDTH  grid columns.
REQ-012 data_o  output  D_WIDTH  ciphertext character, registered.
REQ-013 valid_o  output  1  data_o qualifier, registered.
REQ-014 busy  output  1  high while encrypting; input ignored.

Function
REQ-015 SHALL implement states IDLE (collect) and ENCRYPT.
REQ-016 IDLE: an edge with valid_i=1, busy=0, data_i!=token SHALL store data_i at buffer[count] and increment count; chars beyond MAX_NOF_CHARS are dropped and count saturates.
REQ-017 IDLE: an edge with valid_i=1 and data_i==token SHALL latch key_N, key_M, set busy=1 on that edge, and enter ENCRYPT; token with count=0 is ignored.
REQ-018 Cell p=M*i+j (plaintext row i, column j); ENCRYPT SHALL emit cells with j outer 0..M-1, i inner 0..N-1, one per cycle, N*M cycles total.
REQ-019 First data_o/valid_o SHALL be registered on the edge after the token edge (1-cycle latency); subsequent outputs back-to-back.
REQ-020 Cell p>=count or p>=MAX_NOF_CHARS is empty; handling per REQ-028/029.
REQ-021 Cell index arithmetic SHALL use at least 2*KEY_WIDTH bits; no truncation.
REQ-022 Latched N*M==0 SHALL give zero outputs: busy high one cycle, then IDLE.
REQ-023 On the edge after the last cycle SHALL clear valid_o, busy, count and return to IDLE.
REQ-024 valid_i/data_i while busy=1 SHALL be ignored, including tokens.
REQ-025 Key input changes during ENCRYPT SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, count=0, data_o=0, valid_o=0, busy=0, mid-operation included.
REQ-027 Buffer contents need not be reset; first edge after rst_n rises SHALL accept input.

Configuration
REQ-028 With SCYTALE_ENC_PAD_EN defined, empty cells SHALL be emitted as PAD_CHAR with valid_o=1.
REQ-029 Without SCYTALE_ENC_PAD_EN, empty-cell cycles SHALL drive valid_o=0, data_o held, busy stays high; cycle count unchanged (N*M).

Verification
REQ-030 N=2,M=3, "ABCDEF" then 0xFA -> data_o A,D,B,E,C,F on 6 consecutive cycles, busy low after.
REQ-031 N=2,M=3, "ABCD" then 0xFA -> PAD_EN: A,D,B,' ',C,' '; no PAD_EN: A,D,B,gap,C,gap (valid_o pattern 111010).
REQ-032 0xFA with count=0 -> no output, busy stays 0.
REQ-033 Load "XYZ", keys 3x1, token, assert rst_n=0 after 1 output -> outputs/busy 0 immediately; new "AB"+token with 1x2 -> A,B.
REQ-034 Chars "QRST" during busy of prior message -> ignored; next message output unaffected.
REQ-035 52 chars with N=5,M=10 -> 50 stored, output per REQ-018, chars 51-52 absent.
